// File: rtl/cpu8_pkg.sv
// Shared definitions for the 8-bit accumulator CPU: opcodes, sequencer states, instruction layout.
package cpu8_pkg;

   localparam int unsigned OP_W  = 3;
   localparam int unsigned IMM_W = 5;
   localparam int unsigned CNT_W = 16;

   localparam logic [OP_W-1:0] OP_ACM  = 3'd0;
   localparam logic [OP_W-1:0] OP_ACMI = 3'd1;
   localparam logic [OP_W-1:0] OP_ADD  = 3'd2;
   localparam logic [OP_W-1:0] OP_NAND = 3'd3;
   localparam logic [OP_W-1:0] OP_BNZ  = 3'd4;
   localparam logic [OP_W-1:0] OP_SLT  = 3'd5;
   localparam logic [OP_W-1:0] OP_SW   = 3'd6;
   localparam logic [OP_W-1:0] OP_LW   = 3'd7;

   typedef enum logic [1:0] {
      S_FETCH = 2'd0,
      S_LATCH = 2'd1,
      S_ISSUE = 2'd2,
      S_DMEM  = 2'd3
   } state_e;

   typedef struct packed {
      logic [OP_W-1:0]  opcode;
      logic [IMM_W-1:0] imm;
   } inst_t;

   // Loads and stores need an extra cycle with the accumulator owning memory.
   function automatic logic is_dmem_op(input logic [OP_W-1:0] op);
      return (op == OP_SW) || (op == OP_LW);
   endfunction

endpackage

// File: rtl/instr_fetch_seq_pc_reg.sv
// Program counter: async reset to RESET_PC, branch load has priority over a wrapping increment.
module pc_reg #(
   parameter int unsigned          ADDR_W   = 8,
   parameter logic [ADDR_W-1:0]    RESET_PC = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic              inc,
   input  logic [ADDR_W-1:0] target,
   output logic [ADDR_W-1:0] pc
);

   logic [ADDR_W-1:0] pc_q;
   logic [ADDR_W-1:0] pc_d;

   always_comb begin
      pc_d = pc_q;
      if (load) begin
         pc_d = target;
      end else if (inc) begin
         pc_d = pc_q + ADDR_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_q <= RESET_PC;
      end else begin
         pc_q <= pc_d;
      end
   end

   assign pc = pc_q;

endmodule

// File: rtl/instr_fetch_seq.sv
// Fetch/issue sequencer for the 8-bit accumulator CPU; owns the PC and the memory address mux.
// Optional retired-instruction counter and instr_cnt port enabled by defining INSTR_CNT_EN.
module instr_fetch_seq
   import cpu8_pkg::*;
#(
   parameter int unsigned       ADDR_W   = 8,
   parameter int unsigned       DATA_W   = 8,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              run,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_re,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              sel_mem_in,
   input  logic [ADDR_W-1:0] acc_addr,
   output logic [OP_W-1:0]   opcode,
   output logic [IMM_W-1:0]  imm,
   output logic              inst_valid,
   input  logic              inst_ready,
   input  logic              br_taken,
   input  logic [ADDR_W-1:0] br_target,
   output logic [ADDR_W-1:0] pc
`ifdef INSTR_CNT_EN
   ,
   output logic [CNT_W-1:0]  instr_cnt
`endif
);

   state_e            state_q, state_d;
   inst_t             ir_q, ir_d;
   logic              inst_valid_q, inst_valid_d;
   logic              handshake;
   logic              pc_load, pc_inc;
   logic              mem_re_c, sel_mem_in_c;
   logic [ADDR_W-1:0] mem_addr_c;
   logic [ADDR_W-1:0] pc_cur;

   assign handshake = inst_valid_q & inst_ready;

   // Memory strobes decode the current state so the read lands in S_LATCH with no extra wait cycle.
   always_comb begin
      state_d      = state_q;
      ir_d         = ir_q;
      pc_load      = 1'b0;
      pc_inc       = 1'b0;
      mem_re_c     = 1'b0;
      sel_mem_in_c = 1'b0;
      mem_addr_c   = pc_cur;
      case (state_q)
         S_FETCH: begin
            if (run && !rst) begin
               mem_re_c = 1'b1;
               state_d  = S_LATCH;
            end
         end
         S_LATCH: begin
            ir_d    = inst_t'(mem_rdata[OP_W+IMM_W-1:0]);
            state_d = S_ISSUE;
         end
         S_ISSUE: begin
            if (handshake) begin
               if (is_dmem_op(ir_q.opcode)) begin
                  state_d = S_DMEM;
               end else begin
                  state_d = S_FETCH;
                  if ((ir_q.opcode == OP_BNZ) && br_taken) begin
                     pc_load = 1'b1;
                  end else begin
                     pc_inc = 1'b1;
                  end
               end
            end
         end
         S_DMEM: begin
            sel_mem_in_c = 1'b1;
            mem_addr_c   = acc_addr;
            mem_re_c     = (ir_q.opcode == OP_LW);
            pc_inc       = 1'b1;
            state_d      = S_FETCH;
         end
         default: state_d = S_FETCH;
      endcase
      inst_valid_d = (state_d == S_ISSUE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= S_FETCH;
         ir_q         <= '0;
         inst_valid_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         ir_q         <= ir_d;
         inst_valid_q <= inst_valid_d;
      end
   end

   pc_reg #(
      .ADDR_W   (ADDR_W),
      .RESET_PC (RESET_PC)
   ) u_pc_reg (
      .clk    (clk),
      .rst    (rst),
      .load   (pc_load),
      .inc    (pc_inc),
      .target (br_target),
      .pc     (pc_cur)
   );

`ifdef INSTR_CNT_EN
   logic [CNT_W-1:0] instr_cnt_q, instr_cnt_d;

   // Every retire moves the PC exactly once, so the PC controls double as the retire strobe.
   always_comb begin
      instr_cnt_d = instr_cnt_q;
      if (pc_load || pc_inc) begin
         instr_cnt_d = instr_cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         instr_cnt_q <= '0;
      end else begin
         instr_cnt_q <= instr_cnt_d;
      end
   end

   assign instr_cnt = instr_cnt_q;
`endif

   assign mem_addr   = mem_addr_c;
   assign mem_re     = mem_re_c;
   assign sel_mem_in = sel_mem_in_c;
   assign opcode     = ir_q.opcode;
   assign imm        = ir_q.imm;
   assign inst_valid = inst_valid_q;
   assign pc         = pc_cur;

endmodule

// File: tb/tb_instr_fetch_seq.sv
// Scoreboard bench for instr_fetch_seq: directed programs, expected memory/issue events queued up front.
module tb_instr_fetch_seq;

   logic       clk;
   logic       rst;
   logic       run;
   logic [7:0] mem_addr;
   logic       mem_re;
   logic [7:0] mem_rdata;
   logic       sel_mem_in;
   logic [7:0] acc_addr;
   logic [2:0] opcode;
   logic [4:0] imm;
   logic       inst_valid;
   logic       inst_ready;
   logic       br_taken;
   logic [7:0] br_target;
   logic [7:0] pc;
`ifdef INSTR_CNT_EN
   logic [15:0] instr_cnt;
`endif

   instr_fetch_seq dut (
      .clk        (clk),
      .rst        (rst),
      .run        (run),
      .mem_addr   (mem_addr),
      .mem_re     (mem_re),
      .mem_rdata  (mem_rdata),
      .sel_mem_in (sel_mem_in),
      .acc_addr   (acc_addr),
      .opcode     (opcode),
      .imm        (imm),
      .inst_valid (inst_valid),
      .inst_ready (inst_ready),
      .br_taken   (br_taken),
      .br_target  (br_target),
      .pc         (pc)
`ifdef INSTR_CNT_EN
      ,
      .instr_cnt  (instr_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Registered-read memory: data appears the cycle after the strobe.
   logic [7:0] mem [256];
   always @(posedge clk) begin
      if (mem_re) mem_rdata <= mem[mem_addr];
   end

   typedef struct {
      bit         is_mem;
      logic [7:0] addr;
      logic       re;
      logic       sel;
      logic [2:0] op;
      logic [4:0] imm;
      logic [7:0] pc;
   } exp_t;

   exp_t exp_q[$];
   int   n_pass;
   int   n_total;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_total++;
      if (act === req) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, req);
   endtask

   task automatic push_mem(input logic [7:0] a, input logic re, input logic sel);
      exp_t e;
      e = '{is_mem: 1'b1, addr: a, re: re, sel: sel, op: 3'd0, imm: 5'd0, pc: 8'd0};
      exp_q.push_back(e);
   endtask

   task automatic push_iss(input logic [2:0] op, input logic [4:0] im, input logic [7:0] p);
      exp_t e;
      e = '{is_mem: 1'b0, addr: 8'd0, re: 1'b0, sel: 1'b0, op: op, imm: im, pc: p};
      exp_q.push_back(e);
   endtask

   // Canonical prefix: ACMI 5, SW, LW 3, BNZ at address 3.
   task automatic push_prefix(input logic [7:0] daddr);
      push_mem(8'h00, 1'b1, 1'b0); push_iss(3'd1, 5'd5, 8'h00);
      push_mem(8'h01, 1'b1, 1'b0); push_iss(3'd6, 5'd0, 8'h01);
      push_mem(daddr, 1'b0, 1'b1);
      push_mem(8'h02, 1'b1, 1'b0); push_iss(3'd7, 5'd3, 8'h02);
      push_mem(daddr, 1'b1, 1'b1);
      push_mem(8'h03, 1'b1, 1'b0); push_iss(3'd4, 5'd0, 8'h03);
   endtask

   // Monitor: every memory access or issue handshake must match the head of the queue.
   exp_t e_mon;
   always @(negedge clk) begin
      if (!rst) begin
         if (mem_re || sel_mem_in) begin
            if (exp_q.size() == 0) begin
               n_total++;
               $display("FAIL mem_evt: unexpected access addr=%0h re=%0b sel=%0b, expected none", mem_addr, mem_re, sel_mem_in);
            end else begin
               e_mon = exp_q.pop_front();
               chk("mem_evt {is_mem,addr,re,sel}", {23'd0, 1'b1, mem_addr, mem_re, sel_mem_in},
                   {23'd0, e_mon.is_mem, e_mon.addr, e_mon.re, e_mon.sel});
            end
         end
         if (inst_valid && inst_ready) begin
            if (exp_q.size() == 0) begin
               n_total++;
               $display("FAIL issue_evt: unexpected issue op=%0d imm=%0d pc=%0h, expected none", opcode, imm, pc);
            end else begin
               e_mon = exp_q.pop_front();
               chk("issue_evt {is_mem,op,imm,pc}", {15'd0, 1'b0, opcode, imm, pc},
                   {15'd0, e_mon.is_mem, e_mon.op, e_mon.imm, e_mon.pc});
            end
         end
      end
   end

   task automatic wait_issue(input logic [7:0] p);
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!(inst_valid && pc == p) && n < 200);
      if (!(inst_valid && pc == p)) begin
         n_total++;
         $display("FAIL wait_issue: timed out with pc=%0h, expected issue at pc=%0h", pc, p);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      n_pass = 0;
      n_total = 0;
      for (int i = 0; i < 256; i++) mem[i] = 8'h00;
      mem[8'h00] = 8'h25;  // ACMI 5
      mem[8'h01] = 8'hC0;  // SW
      mem[8'h02] = 8'hE3;  // LW 3
      mem[8'h03] = 8'h80;  // BNZ
      mem[8'h04] = 8'h7F;  // NAND 31
      mem[8'h05] = 8'h1F;  // ACM 31
      mem[8'h06] = 8'h41;  // ADD 1
      mem[8'h10] = 8'hBF;  // SLT 31
      mem[8'hFF] = 8'h5A;  // ADD 26
      rst = 1'b1; run = 1'b0; inst_ready = 1'b1;
      acc_addr = 8'h40; br_taken = 1'b1; br_target = 8'h10;

      // Reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst inst_valid", {31'd0, inst_valid}, 32'd0);
      chk("rst mem_re", {31'd0, mem_re}, 32'd0);
      chk("rst sel_mem_in", {31'd0, sel_mem_in}, 32'd0);
      chk("rst mem_addr", {24'd0, mem_addr}, 32'd0);
      chk("rst opcode/imm", {24'd0, opcode, imm}, 32'd0);
      chk("rst pc", {24'd0, pc}, 32'd0);
`ifdef INSTR_CNT_EN
      chk("rst instr_cnt", {16'd0, instr_cnt}, 32'd0);
`endif

      // Phase 1: prefix with taken branch to 0x10, br inputs asserted for non-branches too
      push_prefix(8'h40);
      push_mem(8'h10, 1'b1, 1'b0); push_iss(3'd5, 5'd31, 8'h10);
      run = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      chk("lat c0 {mem_re,mem_addr}", {23'd0, mem_re, mem_addr}, {23'd0, 1'b1, 8'h00});
      @(negedge clk);
      chk("lat c1 {mem_re,inst_valid}", {30'd0, mem_re, inst_valid}, 32'd0);
      @(negedge clk);
      chk("lat c2 {inst_valid,op,imm}", {23'd0, inst_valid, opcode, imm}, {23'd0, 1'b1, 3'd1, 5'd5});
      @(negedge clk);
      chk("lat c3 pc", {24'd0, pc}, 32'h01);
      wait_issue(8'h10);
      @(posedge clk); #1 run = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("run=0 idle mem_re", {31'd0, mem_re}, 32'd0);
      end
      chk("run=0 pc after SLT", {24'd0, pc}, 32'h11);
`ifdef INSTR_CNT_EN
      chk("instr_cnt phase1", {16'd0, instr_cnt}, 32'd5);
`endif

      // Phase 2: branch not taken at pc=3, seven retires
      @(posedge clk); #1 rst = 1'b1; br_taken = 1'b0; acc_addr = 8'hA5;
      @(negedge clk);
`ifdef INSTR_CNT_EN
      chk("instr_cnt after rst", {16'd0, instr_cnt}, 32'd0);
`endif
      push_prefix(8'hA5);
      push_mem(8'h04, 1'b1, 1'b0); push_iss(3'd3, 5'd31, 8'h04);
      push_mem(8'h05, 1'b1, 1'b0); push_iss(3'd0, 5'd31, 8'h05);
      push_mem(8'h06, 1'b1, 1'b0); push_iss(3'd2, 5'd1, 8'h06);
      run = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      wait_issue(8'h06);
      @(posedge clk); #1 run = 1'b0;
      repeat (2) @(negedge clk);
      chk("phase2 final pc", {24'd0, pc}, 32'h07);
`ifdef INSTR_CNT_EN
      chk("instr_cnt seven", {16'd0, instr_cnt}, 32'd7);
`endif

      // Phase 3: backpressure in S_ISSUE
      @(posedge clk); #1 rst = 1'b1; inst_ready = 1'b0;
      push_mem(8'h00, 1'b1, 1'b0); push_iss(3'd1, 5'd5, 8'h00);
      run = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      wait_issue(8'h00);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("stall {valid,op,imm,pc,mem_re}", {15'd0, inst_valid, opcode, imm, pc, mem_re},
             {15'd0, 1'b1, 3'd1, 5'd5, 8'h00, 1'b0});
      end
      @(posedge clk); #1 inst_ready = 1'b1;
      @(posedge clk); #1 run = 1'b0;
      @(negedge clk);
      chk("stall release pc", {24'd0, pc}, 32'h01);

      // Phase 4: branch to 0xFF, wrap to 0x00, reset during S_LATCH
      @(posedge clk); #1 rst = 1'b1; br_taken = 1'b1; br_target = 8'hFF; acc_addr = 8'h40;
      push_prefix(8'h40);
      push_mem(8'hFF, 1'b1, 1'b0); push_iss(3'd2, 5'd26, 8'hFF);
      push_mem(8'h00, 1'b1, 1'b0);
      run = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      wait_issue(8'hFF);
      @(negedge clk);
      chk("wrap {pc,mem_addr}", {16'd0, pc, mem_addr}, 32'h0000);
      @(posedge clk); #1 rst = 1'b1;
      #1;
      chk("rst in LATCH {valid,re,sel,op,imm,pc}", {14'd0, inst_valid, mem_re, sel_mem_in, opcode, imm, pc},
          32'd0);
`ifdef INSTR_CNT_EN
      chk("rst in LATCH instr_cnt", {16'd0, instr_cnt}, 32'd0);
`endif
      push_mem(8'h00, 1'b1, 1'b0); push_iss(3'd1, 5'd5, 8'h00);
      @(posedge clk); #1 rst = 1'b0;
      wait_issue(8'h00);
      @(posedge clk); #1 run = 1'b0;
      repeat (3) @(negedge clk);
      chk("scoreboard drained", exp_q.size(), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
